// File: rtl/alu_step_control.sv
// Mini-SRC control-step sequencer for R-format ALU instructions.
// Moore FSM: every datapath enable is decoded from the current step alone.
`timescale 1ns/1ps
module alu_step_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        Rin,
  output logic [4:0]  opcode,
  output logic [2:0]  step,
  output logic        instr_done,
  output logic [15:0] instr_count,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [2:0] T0   = 3'd0;
  localparam logic [2:0] T1   = 3'd1;
  localparam logic [2:0] T2   = 3'd2;
  localparam logic [2:0] T3   = 3'd3;
  localparam logic [2:0] T4   = 3'd4;
  localparam logic [2:0] T5   = 3'd5;
  localparam logic [2:0] T6   = 3'd6;
  localparam logic [2:0] IDLE = 3'd7;

  // wait_cnt equals the zero-based index of the current T2 cycle
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [7:0] wait_cnt;
  logic       set_illegal;
  logic       set_mem_err;
  logic       op_valid;
  logic       unused_ir;

  assign unused_ir = ^IR[26:0];
  assign op_valid  = (IR[31:27] >= 5'd3) && (IR[31:27] <= 5'd11);

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    case (state)
      IDLE: if (run && !mem_err) state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = T2;
      T2: begin
        if (mem_ready) begin
          state_next = T3;
        end else if (wait_cnt == WAIT_LAST) begin
          set_mem_err = 1'b1;
          state_next  = IDLE;
        end
      end
      T3:   state_next = T4;
      T4: begin
        if (op_valid) begin
          state_next = T5;
        end else begin
          set_illegal = 1'b1;
          state_next  = T0;
        end
      end
      T5:   state_next = T6;
      T6:   state_next = run ? T0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      instr_count <= 16'd0;
      illegal     <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == T1) begin
        wait_cnt <= 8'd0;
      end else if (state == T2 && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == T6) instr_count <= instr_count + 16'd1;
      if (set_illegal) illegal <= 1'b1;
      if (set_mem_err) mem_err <= 1'b1;
    end
  end

  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rout       = 1'b0;
    Rin        = 1'b0;
    opcode     = 5'b00000;
    instr_done = 1'b0;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      T2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T4: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
      end
      T5: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        opcode = IR[31:27];
      end
      T6: begin
        Zlowout    = 1'b1;
        Gra        = 1'b1;
        Rin        = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign step = state;

endmodule

// File: tb/tb_alu_step_control.sv
// Randomized bench for alu_step_control; expected step sequences are built
// per instruction from opcode legality and memory wait count.
`timescale 1ns/1ps
module tb_alu_step_control;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [15:0] E_PCOUT   = 16'h8000;
  localparam logic [15:0] E_MARIN   = 16'h4000;
  localparam logic [15:0] E_INCPC   = 16'h2000;
  localparam logic [15:0] E_ZIN     = 16'h1000;
  localparam logic [15:0] E_ZLOWOUT = 16'h0800;
  localparam logic [15:0] E_PCIN    = 16'h0400;
  localparam logic [15:0] E_READ    = 16'h0200;
  localparam logic [15:0] E_MDRIN   = 16'h0100;
  localparam logic [15:0] E_MDROUT  = 16'h0080;
  localparam logic [15:0] E_IRIN    = 16'h0040;
  localparam logic [15:0] E_YIN     = 16'h0020;
  localparam logic [15:0] E_GRA     = 16'h0010;
  localparam logic [15:0] E_GRB     = 16'h0008;
  localparam logic [15:0] E_GRC     = 16'h0004;
  localparam logic [15:0] E_ROUT    = 16'h0002;
  localparam logic [15:0] E_RIN     = 16'h0001;

  logic        clk = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic        MDRout, IRin, Yin, Gra, Grb, Grc, Rout, Rin;
  logic [4:0]  opcode;
  logic [2:0]  step;
  logic        instr_done;
  logic [15:0] instr_count;
  logic        illegal;
  logic        mem_err;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [15:0] expCount;
  logic        expIllegal;
  logic        expMemErr;
  logic [15:0] en;

  assign en = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
               MDRout, IRin, Yin, Gra, Grb, Grc, Rout, Rin};

  alu_step_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rout(Rout), .Rin(Rin), .opcode(opcode), .step(step),
    .instr_done(instr_done), .instr_count(instr_count),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] specEn(input int s);
    case (s)
      0:       return E_PCOUT | E_MARIN | E_INCPC | E_ZIN;
      1:       return E_ZLOWOUT | E_PCIN;
      2:       return E_READ | E_MDRIN;
      3:       return E_MDROUT | E_IRIN;
      4:       return E_GRB | E_ROUT | E_YIN;
      5:       return E_GRC | E_ROUT | E_ZIN;
      6:       return E_ZLOWOUT | E_GRA | E_RIN;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCycle(input int s, input logic [4:0] op);
    checkOutput("step", 32'(step), 32'(s));
    checkOutput("enables", 32'(en), 32'(specEn(s)));
    checkOutput("opcode", 32'(opcode), (s == 5) ? 32'(op) : 32'd0);
    checkOutput("instr_done", 32'(instr_done), (s == 6) ? 32'd1 : 32'd0);
    checkOutput("instr_count", 32'(instr_count), 32'(expCount));
    checkOutput("illegal", 32'(illegal), 32'(expIllegal));
    checkOutput("mem_err", 32'(mem_err), 32'(expMemErr));
  endtask

  task automatic resetModel();
    expCount   = 16'd0;
    expIllegal = 1'b0;
    expMemErr  = 1'b0;
  endtask

  task automatic startFromIdle();
    @(negedge clk);
    checkCycle(7, 5'd0);
    run = 1'b1;
  endtask

  // Runs one instruction whose first T0 edge is the next rising edge.
  task automatic applyStimulus(input logic [4:0] op, input int waits, input bit keepRun,
                               input bit dropAtT3, input bit clearAtT5);
    int  q[$];
    int  t2idx;
    int  nT2;
    bit  legal;
    bit  timeout;
    legal   = (op >= 5'd3) && (op <= 5'd11);
    timeout = (waits >= MEM_TIMEOUT);
    nT2     = timeout ? MEM_TIMEOUT : waits + 1;
    t2idx   = 0;
    q.push_back(0);
    q.push_back(1);
    repeat (nT2) q.push_back(2);
    if (!timeout) begin
      q.push_back(3);
      q.push_back(4);
      if (legal) begin
        q.push_back(5);
        q.push_back(6);
      end
    end
    foreach (q[i]) begin
      @(negedge clk);
      checkCycle(q[i], op);
      if (i == 0) IR = {op, 27'($urandom)};
      mem_ready = (q[i] == 2) && (t2idx == waits);
      if (q[i] == 2) t2idx++;
      if (q[i] == 2 && timeout && t2idx == MEM_TIMEOUT) expMemErr = 1'b1;
      if (dropAtT3 && q[i] == 3) run = 1'b0;
      if (q[i] == 4 && !legal) expIllegal = 1'b1;
      if (q[i] == 6) begin
        expCount = expCount + 16'd1;
        run      = keepRun;
      end
      if (clearAtT5 && q[i] == 5) begin
        #2 clear = 1'b1;
        #1;
        resetModel();
        checkCycle(7, 5'd0);
        checkOutput("clr_zin", 32'(Zin), 32'd0);
        #1 clear = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    bit inIdle;
    clear     = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    IR        = 32'd0;
    resetModel();
    #12;
    checkCycle(7, 5'd0);
    @(negedge clk);
    clear = 1'b0;

    $display("[TB] legal add");
    startFromIdle();
    applyStimulus(5'b00011, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] memory wait, back-to-back into illegal and legal");
    startFromIdle();
    applyStimulus(5'b00101, 3, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'b01100, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'b01011, 1, 1'b1, 1'b0, 1'b0);

    $display("[TB] run dropped in T3");
    applyStimulus(5'b00100, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkCycle(7, 5'd0);

    $display("[TB] clear during T5");
    startFromIdle();
    applyStimulus(5'b00111, 2, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'b01000, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random instructions");
    inIdle = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      int         waits;
      bit         keep;
      op    = 5'($urandom_range(0, 31));
      waits = $urandom_range(0, 4);
      keep  = 1'($urandom_range(0, 1));
      if (inIdle) startFromIdle();
      applyStimulus(op, waits, keep, 1'b0, 1'b0);
      inIdle = ((op >= 5'd3) && (op <= 5'd11)) ? !keep : 1'b0;
    end

    $display("[TB] memory timeout");
    if (inIdle) startFromIdle();
    applyStimulus(5'b00011, MEM_TIMEOUT, 1'b1, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checkCycle(7, 5'd0);
    end
    clear = 1'b1;
    #1;
    resetModel();
    checkCycle(7, 5'd0);
    @(negedge clk);
    clear = 1'b0;
    run   = 1'b0;

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_step_control.md
# alu_step_control

Control-step sequencer that sits directly upstream of the 32-bit ALU in the Mini-SRC datapath. It runs the fetch/execute control steps for R-format ALU instructions (Add, Sub, Shr, Shra, Shl, Ror, Rol, And, Or). It drives the ALU's `opcode` and `IncPC` inputs and the bus/register enables that place operands on the ALU's A/B inputs and capture its LO result into Z and then Ra. Memory reads use a ready handshake with timeout; completed instructions are counted.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of T2 cycles spent waiting for `mem_ready`. Legal range 1–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `run` in 1: start/continue request, sampled only at instruction boundaries.
- `IR` in 32: instruction register contents. `IR[31:27]` is the opcode.
- `mem_ready` in 1: memory read data is valid on the MDR input this cycle.
- `PCout`, `MARin`, `IncPC`, `Zin`, `Zlowout`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Gra`, `Grb`, `Grc`, `Rout`, `Rin` out 1 each: datapath control enables.
- `opcode` out 5: ALU operation select.
- `step` out 3: current state encoding. IDLE=7, T0..T6=0..6.
- `instr_done` out 1: one-cycle pulse in T6.
- `instr_count` out 16: count of completed instructions.
- `illegal` out 1: sticky flag, set by an undefined opcode.
- `mem_err` out 1: sticky flag, set by a memory timeout.

## Operation
- Moore FSM. All control outputs are decoded from the state register only. Any enable not listed for a state is 0.
- **IDLE**: no enables asserted.
  - Goes to T0 when `run`=1 and `mem_err`=0.
- **T0**: `PCout`, `MARin`, `IncPC`, `Zin` (PC+1 into Z). Goes to T1.
- **T1**: `Zlowout`, `PCin`. Goes to T2.
- **T2**: `Read`, `MDRin`, held for every cycle spent in T2.
  - `mem_ready`=1 → T3. This takes priority over timeout on the same cycle.
  - `mem_ready`=0 on the MEM_TIMEOUT-th T2 cycle → set `mem_err`, go to IDLE.
  - 8-bit wait counter is cleared on entry to T2 and increments on each T2 cycle with `mem_ready`=0.
- **T3**: `MDRout`, `IRin`. Goes to T4.
- **T4**: `Grb`, `Rout`, `Yin`. Decodes `IR[31:27]`:
  - Valid opcodes are 00011–01011 → T5.
  - Any other opcode (00000–00010, 01100–11111) → set `illegal`, go to T0. No writeback and no count increment.
- **T5**: `Grc`, `Rout`, `Zin`, and `opcode`=`IR[31:27]`. Goes to T6.
  - Outside T5, `opcode`=5'b00000.
  - `IncPC` is 1 only in T0.
- **T6**: `Zlowout`, `Gra`, `Rin`, `instr_done`. Increments `instr_count` (16-bit, wraps 0xFFFF→0x0000).
  - Goes to T0 if `run`=1, else IDLE.
- `run` is ignored in T0–T5. Dropping `run` mid-instruction never aborts the instruction.
- `illegal` and `mem_err` clear only on `clear`.
  - `mem_err`=1 holds the FSM in IDLE regardless of `run`.
  - `illegal` does not halt the FSM.

## Timing
- `clear` asserted at any time, including mid-instruction: state goes to IDLE immediately (asynchronous).
  - All enables and `instr_done` are 0; `opcode`=0; `step`=7.
  - `instr_count`=0, `illegal`=0, `mem_err`=0, wait counter=0.
- On `clear` deassertion, the first edge with `run`=1 enters T0.
- Legal instruction with `mem_ready`=1 in the first T2 cycle: 7 cycles, T0 through T6.
  - Each additional T2 wait cycle adds 1 cycle.
- Back-to-back instructions: T6 goes directly to T0 with no bubble.
- Illegal instruction: 5 cycles (T0–T4), then T0.
- Maximum time in T2 is MEM_TIMEOUT cycles. `mem_err` is visible the cycle after the last T2 cycle.
- Outputs change only after rising edges of `clk` or on `clear` assertion.

## Test plan
- Legal Add: `clear` pulse, `run`=1, `mem_ready`=1, `IR[31:27]`=00011. Expect:
  - `step` sequence 0,1,2,3,4,5,6,0.
  - `opcode`=00011 only in the T5 cycle; `IncPC`=1 only in T0.
  - `instr_done` pulses in cycle 7; `instr_count`=1.
- Memory wait: `mem_ready` low for 3 T2 cycles, then high. Expect:
  - T2 lasts 4 cycles with `Read`/`MDRin` held high throughout.
  - Instruction takes 10 cycles; `mem_err`=0.
- Timeout: `mem_ready` held at 0, MEM_TIMEOUT=15. Expect:
  - 15 T2 cycles, then `mem_err`=1 and `step`=7.
  - FSM stays in IDLE with `run`=1 until `clear`.
- Illegal opcode 01100. Expect:
  - `illegal`=1 after T4, then next `step`=0.
  - `Rin` never asserted; `instr_count` unchanged.
  - Next legal instruction completes normally with `illegal` still 1.
- `run` dropped during T3. Expect:
  - Instruction completes through T6 with `instr_done`=1, then IDLE.
  - Separately, preload 65535 completions; the next completion wraps `instr_count` to 0.
- `clear` asserted during T5. Expect:
  - Same cycle: `step`=7, `Zin`=0, `opcode`=0, counters and flags 0.
  - After release with `run`=1: a fresh T0.
